// File: rtl/mem_req_seq.sv
//-----------------------------------------------------------------------------
// mem_req_seq
//
// Memory request sequencer for the CMI side of the memory-control chip.
// Microcode bus requests are queued in a small FIFO, and a single I-stream
// prefetch can be held pending. The sequencer issues them to the CMI one at
// a time. Each issued cycle runs IDLE -> ADDR -> WAIT. The cycle ends when
// STATUS VALID L is seen low, or when a bounded wait counter expires.
//
// Build option:
//   MEM_REQ_SEQ_PREFETCH_EN  defined   : prefetch-pending / discard path present
//                            undefined : only FIFO entries are issued,
//                                        pf_req_h/pf_cancel_h are ignored and
//                                        cyc_pf_h is tied low
//
// Parameters:
//   DEPTH  request FIFO entries (power of two, 2..16)
//   TMO_W  wait counter width; cyc_tmo_h fires 2^TMO_W cycles after ADDR
//
// Ports:
//   b_clk_l         clock, rising edge
//   proc_init_l     asynchronous active-low reset
//   req_valid_h     microcode request present
//   req_cmd_h       microcode BUS field code
//   req_read_h      request is a read
//   req_ready_h     FIFO can accept (registered count < DEPTH)
//   pf_req_h        set prefetch-pending
//   pf_cancel_h     cancel pending or in-flight prefetch
//   inval_check_h   holds off issue while high
//   cmi_grant_h     CMI free to start a cycle
//   status_valid_l  low = current CMI cycle complete (sampled in WAIT only)
//   add_reg_ena_h   one-cycle issue pulse (ADDR state)
//   cyc_cmd_h       command of current cycle (5'h1F for prefetch)
//   cyc_read_h      current cycle is a read
//   cyc_pf_h        current cycle is a prefetch
//   cyc_in_prog_h   cycle issued and awaiting completion (WAIT state)
//   cyc_done_h      one-cycle completion pulse
//   cyc_tmo_h       one-cycle timeout pulse
//   q_count_h       FIFO occupancy
//-----------------------------------------------------------------------------
`default_nettype none

module mem_req_seq #(
  parameter int DEPTH = 4,
  parameter int TMO_W = 8
) (
  input  logic                       b_clk_l,
  input  logic                       proc_init_l,
  input  logic                       req_valid_h,
  input  logic [4:0]                 req_cmd_h,
  input  logic                       req_read_h,
  output logic                       req_ready_h,
  input  logic                       pf_req_h,
  input  logic                       pf_cancel_h,
  input  logic                       inval_check_h,
  input  logic                       cmi_grant_h,
  input  logic                       status_valid_l,
  output logic                       add_reg_ena_h,
  output logic [4:0]                 cyc_cmd_h,
  output logic                       cyc_read_h,
  output logic                       cyc_pf_h,
  output logic                       cyc_in_prog_h,
  output logic                       cyc_done_h,
  output logic                       cyc_tmo_h,
  output logic [$clog2(DEPTH+1)-1:0] q_count_h
);

  localparam int         PTR_W  = $clog2(DEPTH);
  localparam int         CNT_W  = $clog2(DEPTH + 1);
  localparam logic [4:0] PF_CMD = 5'h1F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] cmd;
    logic       read;
  } req_t;

  state_e           state_q, state_d;
  req_t             fifo_mem_q [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
  logic [4:0]       cyc_cmd_q, cyc_cmd_d;
  logic             cyc_read_q, cyc_read_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             push, pop, issue;
  logic             fifo_nonempty;
  logic             pf_avail;
  logic             suppress_done;

  //---------------------------------------------------------------------------
  // Request FIFO
  //---------------------------------------------------------------------------
  // Ready comes from the registered count only. A full FIFO therefore
  // refuses a push even in the cycle it is being popped.
  assign req_ready_h   = (count_q < CNT_W'(DEPTH));
  assign push          = req_valid_h & req_ready_h;
  assign fifo_nonempty = (count_q != '0);
  assign head          = fifo_mem_q[rd_ptr_q];

  // An issue starts from IDLE. The FIFO head wins over a pending prefetch,
  // so a pop happens whenever an issue finds the FIFO non-empty.
  assign issue = (state_q == S_IDLE) & ~inval_check_h & cmi_grant_h &
                 (fifo_nonempty | pf_avail);
  assign pop   = issue & fifo_nonempty;

  // NOTE: the storage array has no reset. Entries are only read once the
  // count says they were written, so clearing them would buy nothing.
  always_ff @(posedge b_clk_l) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= '{cmd: req_cmd_h, read: req_read_h};
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  // NOTE: state flops use non-blocking assignments. Every flop then samples
  // the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge b_clk_l or negedge proc_init_l) begin
    if (!proc_init_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  //---------------------------------------------------------------------------
  // Prefetch pending / discard
  //---------------------------------------------------------------------------
`ifdef MEM_REQ_SEQ_PREFETCH_EN
  logic pf_pend_q, pf_pend_d;
  logic discard_q, discard_d;
  logic cyc_pf_q;
  logic issue_pf;

  // A cancel in the issue cycle keeps the prefetch from going out.
  assign pf_avail = pf_pend_q & ~pf_cancel_h;
  assign issue_pf = issue & ~fifo_nonempty;

  // Completion is suppressed if the prefetch was cancelled earlier in the
  // cycle, or is being cancelled in the very cycle it completes.
  assign suppress_done = discard_q | (pf_cancel_h & cyc_pf_q);

  // Cancel beats a new request. A request arriving as the old one issues
  // leaves a fresh prefetch pending.
  always_comb begin
    pf_pend_d = pf_pend_q;
    if (pf_cancel_h) begin
      pf_pend_d = 1'b0;
    end else if (pf_req_h) begin
      pf_pend_d = 1'b1;
    end else if (issue_pf) begin
      pf_pend_d = 1'b0;
    end
  end

  always_comb begin
    discard_d = discard_q;
    if (state_d == S_IDLE) begin
      discard_d = 1'b0;
    end else if ((state_q != S_IDLE) && cyc_pf_q && pf_cancel_h) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge b_clk_l or negedge proc_init_l) begin
    if (!proc_init_l) begin
      pf_pend_q <= 1'b0;
      discard_q <= 1'b0;
      cyc_pf_q  <= 1'b0;
    end else begin
      pf_pend_q <= pf_pend_d;
      discard_q <= discard_d;
      if (issue) cyc_pf_q <= issue_pf;
    end
  end

  assign cyc_pf_h = cyc_pf_q;
`else
  logic unused_pf;

  assign pf_avail      = 1'b0;
  assign suppress_done = 1'b0;
  assign cyc_pf_h      = 1'b0;
  assign unused_pf     = pf_req_h ^ pf_cancel_h;
`endif

  //---------------------------------------------------------------------------
  // Cycle FSM
  //---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    tmo_cnt_inc = tmo_cnt_q + TMO_W'(1);
    cyc_cmd_d   = cyc_cmd_q;
    cyc_read_d  = cyc_read_q;
    done_d      = 1'b0;
    tmo_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_ADDR;
          if (fifo_nonempty) begin
            cyc_cmd_d  = head.cmd;
            cyc_read_d = head.read;
          end else begin
            cyc_cmd_d  = PF_CMD;
            cyc_read_d = 1'b1;
          end
        end
      end

      S_ADDR: begin
        state_d   = S_WAIT;
        tmo_cnt_d = '0;
      end

      S_WAIT: begin
        if (!status_valid_l) begin
          done_d  = ~suppress_done;
          state_d = S_IDLE;
        end else begin
          // The counter holds wait cycles minus one. It reaches all-ones on
          // the (2^TMO_W-1)th wait cycle, so the registered pulse lands
          // 2^TMO_W cycles after ADDR.
          tmo_cnt_d = tmo_cnt_inc;
          if (&tmo_cnt_inc) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset in mid-cycle drops the cycle and clears the pulses. No done or
  // timeout is reported for the abandoned cycle.
  always_ff @(posedge b_clk_l or negedge proc_init_l) begin
    if (!proc_init_l) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= '0;
      cyc_cmd_q  <= '0;
      cyc_read_q <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      cyc_cmd_q  <= cyc_cmd_d;
      cyc_read_q <= cyc_read_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  assign add_reg_ena_h = (state_q == S_ADDR);
  assign cyc_in_prog_h = (state_q == S_WAIT);
  assign cyc_cmd_h     = cyc_cmd_q;
  assign cyc_read_h    = cyc_read_q;
  assign cyc_done_h    = done_q;
  assign cyc_tmo_h     = tmo_q;
  assign q_count_h     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_seq.sv
//-----------------------------------------------------------------------------
// Testbench for mem_req_seq (DEPTH=4, TMO_W=4).
// Issued commands are checked against a scoreboard queue. Accepted pushes
// (and the expected prefetch) are enqueued when driven, and the queue is
// popped on each add_reg_ena_h. Cycle timing comes from a table of vectors
// plus hand-written sequences. The prefetch path is exercised when
// MEM_REQ_SEQ_PREFETCH_EN is defined; otherwise the bench checks that
// prefetch requests are ignored.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_req_seq;

  localparam int DEPTH = 4;
  localparam int TMO_W = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             b_clk_l;
  logic             proc_init_l;
  logic             req_valid_h;
  logic [4:0]       req_cmd_h;
  logic             req_read_h;
  logic             req_ready_h;
  logic             pf_req_h;
  logic             pf_cancel_h;
  logic             inval_check_h;
  logic             cmi_grant_h;
  logic             status_valid_l;
  logic             add_reg_ena_h;
  logic [4:0]       cyc_cmd_h;
  logic             cyc_read_h;
  logic             cyc_pf_h;
  logic             cyc_in_prog_h;
  logic             cyc_done_h;
  logic             cyc_tmo_h;
  logic [CNT_W-1:0] q_count_h;

  mem_req_seq #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .b_clk_l        (b_clk_l),
    .proc_init_l    (proc_init_l),
    .req_valid_h    (req_valid_h),
    .req_cmd_h      (req_cmd_h),
    .req_read_h     (req_read_h),
    .req_ready_h    (req_ready_h),
    .pf_req_h       (pf_req_h),
    .pf_cancel_h    (pf_cancel_h),
    .inval_check_h  (inval_check_h),
    .cmi_grant_h    (cmi_grant_h),
    .status_valid_l (status_valid_l),
    .add_reg_ena_h  (add_reg_ena_h),
    .cyc_cmd_h      (cyc_cmd_h),
    .cyc_read_h     (cyc_read_h),
    .cyc_pf_h       (cyc_pf_h),
    .cyc_in_prog_h  (cyc_in_prog_h),
    .cyc_done_h     (cyc_done_h),
    .cyc_tmo_h      (cyc_tmo_h),
    .q_count_h      (q_count_h)
  );

  initial b_clk_l = 1'b0;
  always #5 b_clk_l = ~b_clk_l;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] cmd;
    logic       read;
    logic       pf;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [4:0] cmd;
    logic       read;
    int         wait_n;      // WAIT cycles before status low; 0 = never
    int         exp_inprog;
    int         exp_done;
    int         exp_tmo;
    int         exp_span;    // cycles from ADDR to the done/tmo pulse
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge b_clk_l);
    #1;
  endtask

  task automatic push_req(input logic [4:0] cmd, input logic rd);
    req_valid_h = 1'b1;
    req_cmd_h   = cmd;
    req_read_h  = rd;
    tick();
    req_valid_h = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_add"},    add_reg_ena_h, 0);
    check({tag, "_cmd"},    cyc_cmd_h,     0);
    check({tag, "_read"},   cyc_read_h,    0);
    check({tag, "_pf"},     cyc_pf_h,      0);
    check({tag, "_inprog"}, cyc_in_prog_h, 0);
    check({tag, "_done"},   cyc_done_h,    0);
    check({tag, "_tmo"},    cyc_tmo_h,     0);
    check({tag, "_count"},  q_count_h,     0);
    check({tag, "_ready"},  req_ready_h,   1);
  endtask

  // Follows one cycle from the current point until its done/tmo pulse.
  // Drives status_valid_l low in the wait_n-th WAIT cycle, and returns one
  // clock after the pulse.
  task automatic run_cycle(input int wait_n, output int first_addr, output int end_cyc,
                           output int n_inprog, output int n_done, output int n_tmo);
    first_addr = -1;
    end_cyc    = -1;
    n_inprog   = 0;
    n_done     = 0;
    n_tmo      = 0;
    for (int c = 0; c < 60; c++) begin
      status_valid_l = 1'b1;
      if (add_reg_ena_h && first_addr < 0) first_addr = c;
      if (cyc_done_h) n_done++;
      if (cyc_tmo_h)  n_tmo++;
      if (cyc_done_h || cyc_tmo_h) begin
        end_cyc = c;
        break;
      end
      if (cyc_in_prog_h) begin
        n_inprog++;
        if (wait_n > 0 && n_inprog == wait_n) status_valid_l = 1'b0;
      end
      tick();
    end
    status_valid_l = 1'b1;
    tick();
  endtask

  // Scoreboard producer: every accepted push.
  always @(posedge b_clk_l) begin : sb_push
    exp_t e;
    if (proc_init_l === 1'b1 && req_valid_h && req_ready_h) begin
      e = {req_cmd_h, req_read_h, 1'b0};
      exp_q.push_back(e);
    end
  end

  // Scoreboard consumer: every issue pulse.
  always @(negedge b_clk_l) begin : sb_pop
    exp_t e;
    if (proc_init_l === 1'b1 && add_reg_ena_h) begin
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_cmd",  cyc_cmd_h,  e.cmd);
        check("sb_read", cyc_read_h, e.read);
        check("sb_pf",   cyc_pf_h,   e.pf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: test did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   fa, ec, ni, nd, nt, n;
    exp_t e;

    vecs[0] = '{5'h03, 1'b1, 1, 1,  1, 0, 2};
    vecs[1] = '{5'h0A, 1'b0, 2, 2,  1, 0, 3};
    vecs[2] = '{5'h15, 1'b1, 5, 5,  1, 0, 6};
    vecs[3] = '{5'h1E, 1'b0, 0, 15, 0, 1, 16};

    proc_init_l    = 1'b0;
    req_valid_h    = 1'b0;
    req_cmd_h      = '0;
    req_read_h     = 1'b0;
    pf_req_h       = 1'b0;
    pf_cancel_h    = 1'b0;
    inval_check_h  = 1'b0;
    cmi_grant_h    = 1'b0;
    status_valid_l = 1'b1;

    // Reset values
    #12;
    check_reset_outputs("rst");
    tick();
    proc_init_l = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    // Basic read: issue at N+2, 3 in-progress cycles, one done pulse
    cmi_grant_h = 1'b1;
    push_req(5'h01, 1'b1);
    check("basic_count1", q_count_h, 1);
    check("basic_add_n1", add_reg_ena_h, 0);
    run_cycle(3, fa, ec, ni, nd, nt);
    check("basic_first_addr", fa, 1);
    check("basic_inprog", ni, 3);
    check("basic_done", nd, 1);
    check("basic_tmo", nt, 0);
    check("basic_span", ec - fa, 4);
    check("basic_count0", q_count_h, 0);

    // Table-driven cycles
    foreach (vecs[i]) begin
      push_req(vecs[i].cmd, vecs[i].read);
      run_cycle(vecs[i].wait_n, fa, ec, ni, nd, nt);
      check($sformatf("vec%0d_first_addr", i), fa, 1);
      check($sformatf("vec%0d_inprog", i), ni, vecs[i].exp_inprog);
      check($sformatf("vec%0d_done", i), nd, vecs[i].exp_done);
      check($sformatf("vec%0d_tmo", i), nt, vecs[i].exp_tmo);
      check($sformatf("vec%0d_span", i), ec - fa, vecs[i].exp_span);
    end

    // Full FIFO: fifth push refused; refused also while a pop happens
    cmi_grant_h = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid_h = 1'b1;
      req_cmd_h   = 5'h10 + 5'(i);
      req_read_h  = i[0];
      if (i == 4) begin
        check("full_ready", req_ready_h, 0);
        check("full_count", q_count_h, 4);
      end
      tick();
    end
    req_valid_h = 1'b0;
    check("full_count_hold", q_count_h, 4);
    cmi_grant_h = 1'b1;
    req_valid_h = 1'b1;
    req_cmd_h   = 5'h07;
    req_read_h  = 1'b1;
    check("full_pop_ready", req_ready_h, 0);
    tick();
    req_valid_h = 1'b0;
    check("full_pop_count", q_count_h, 3);
    check("full_pop_add", add_reg_ena_h, 1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1, fa, ec, ni, nd, nt);
      check($sformatf("drain%0d_first_addr", i), fa, 0);
      check($sformatf("drain%0d_done", i), nd, 1);
    end
    check("drain_count", q_count_h, 0);
    check("drain_sb_empty", exp_q.size(), 0);

    // Blocking by inval_check_h, then push+pop in the same cycle
    inval_check_h = 1'b1;
    push_req(5'h09, 1'b0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (add_reg_ena_h) n++;
      tick();
    end
    check("inval_no_issue", n, 0);
    check("inval_count", q_count_h, 1);
    inval_check_h = 1'b0;
    req_valid_h   = 1'b1;
    req_cmd_h     = 5'h0B;
    req_read_h    = 1'b1;
    tick();
    req_valid_h = 1'b0;
    check("pushpop_count", q_count_h, 1);
    check("inval_release_add", add_reg_ena_h, 1);
    run_cycle(1, fa, ec, ni, nd, nt);
    check("inval_done", nd, 1);
    run_cycle(2, fa, ec, ni, nd, nt);
    check("pushpop_first_addr", fa, 0);
    check("pushpop_done", nd, 1);

    // Timeout then next entry issues
    cmi_grant_h = 1'b0;
    push_req(5'h0C, 1'b1);
    push_req(5'h0D, 1'b0);
    cmi_grant_h = 1'b1;
    run_cycle(0, fa, ec, ni, nd, nt);
    check("tmo_first_addr", fa, 1);
    check("tmo_span", ec - fa, 16);
    check("tmo_pulse", nt, 1);
    check("tmo_no_done", nd, 0);
    check("tmo_inprog", ni, 15);
    run_cycle(1, fa, ec, ni, nd, nt);
    check("after_tmo_first_addr", fa, 0);
    check("after_tmo_done", nd, 1);

`ifdef MEM_REQ_SEQ_PREFETCH_EN
    // FIFO before prefetch; cancel during prefetch WAIT suppresses done
    req_valid_h = 1'b1;
    req_cmd_h   = 5'h08;
    req_read_h  = 1'b0;
    pf_req_h    = 1'b1;
    tick();
    req_valid_h = 1'b0;
    pf_req_h    = 1'b0;
    e = '{cmd: 5'h1F, read: 1'b1, pf: 1'b1};
    exp_q.push_back(e);
    run_cycle(1, fa, ec, ni, nd, nt);
    check("prio_fifo_first_addr", fa, 1);
    check("prio_fifo_done", nd, 1);
    check("pf_add", add_reg_ena_h, 1);
    check("pf_cmd", cyc_cmd_h, 5'h1F);
    check("pf_read", cyc_read_h, 1);
    check("pf_flag", cyc_pf_h, 1);
    tick();
    check("pf_inprog", cyc_in_prog_h, 1);
    pf_cancel_h = 1'b1;
    tick();
    pf_cancel_h    = 1'b0;
    status_valid_l = 1'b0;
    tick();
    status_valid_l = 1'b1;
    check("pf_cancel_no_done", cyc_done_h, 0);
    check("pf_cancel_idle", cyc_in_prog_h, 0);
    check("pf_cancel_no_tmo", cyc_tmo_h, 0);
    tick();
    check("pf_cancel_no_done2", cyc_done_h, 0);
`else
    // Prefetch path absent: pf_req_h must not start a cycle
    pf_req_h = 1'b1;
    tick();
    pf_req_h = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (add_reg_ena_h) n++;
      tick();
    end
    check("nopf_no_issue", n, 0);
    check("nopf_cyc_pf", cyc_pf_h, 0);
`endif

    // Reset in the middle of WAIT
    push_req(5'h12, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (cyc_in_prog_h) break;
      tick();
    end
    check("midrst_reached_wait", cyc_in_prog_h, 1);
    #2;
    proc_init_l = 1'b0;
    #1;
    check_reset_outputs("midrst");
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cyc_done_h || cyc_tmo_h) n++;
    end
    exp_q.delete();
    proc_init_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cyc_done_h || cyc_tmo_h) n++;
    end
    check("midrst_no_pulse", n, 0);
    check("midrst_count", q_count_h, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
